// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache.
// Sits between the MEM stage and a 256-bit line-wide data memory. It
// produces the pipeline stall and runs a small FSM that does the write-back
// of a dirty victim, the line fill, and then lets the held access retry.
module dcache_ctrl #(
  parameter int unsigned LINES  = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [2:0] {IDLE, MISS, WB, FILL, DONE} state_t;

  state_t            state_q;
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Index/tag of the access being serviced, latched so a flushed request
  // (req dropped mid-miss) still completes its fill into the right line.
  logic [IDX_W-1:0]  miss_idx_q;
  logic [TAG_W-1:0]  miss_tag_q;

  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [2:0]        cpu_word;
  logic              req;
  logic              hit;
  logic              store_hit;
  logic              fill_done;
  logic [LINE_W-1:0] rd_line;
  logic [31:0]       rd_word;
  logic              addr_unused;

  assign cpu_idx     = cpu_addr_i[5 +: IDX_W];
  assign cpu_tag     = cpu_addr_i[31 -: TAG_W];
  assign cpu_word    = cpu_addr_i[4:2];
  assign addr_unused = ^cpu_addr_i[1:0];

  assign req       = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign store_hit = !rst_i && (state_q == IDLE) && cpu_MemWrite_i && hit;
  assign fill_done = !rst_i && (state_q == FILL) && mem_enable_o && mem_ack_i;

  assign rd_line = data_q[cpu_idx];
  assign rd_word = rd_line[{cpu_word, 5'b0} +: 32];

  assign cpu_stall_o = !rst_i && req && ((state_q != IDLE) || !hit);

  // Loads return data only on an unstalled hit; a combined read+write is a store.
  assign cpu_data_o = (!rst_i && cpu_MemRead_i && !cpu_MemWrite_i &&
                       (state_q == IDLE) && hit) ? rd_word : '0;

  // Miss-service FSM with registered memory-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            miss_idx_q <= cpu_idx;
            miss_tag_q <= cpu_tag;
            state_q    <= MISS;
          end
        end
        MISS: begin
          mem_enable_o <= 1'b1;
          if (valid_q[miss_idx_q] && dirty_q[miss_idx_q]) begin
            state_q     <= WB;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_q[miss_idx_q], miss_idx_q, 5'b0};
            mem_data_o  <= data_q[miss_idx_q];
          end else begin
            state_q     <= FILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {miss_tag_q, miss_idx_q, 5'b0};
          end
        end
        WB: begin
          // Drop enable for one cycle between write-back and fill; FILL
          // re-raises it, so the gap costs exactly one extra stall cycle.
          if (mem_ack_i) begin
            state_q      <= FILL;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= {miss_tag_q, miss_idx_q, 5'b0};
          end
        end
        FILL: begin
          if (!mem_enable_o) begin
            mem_enable_o <= 1'b1;
          end else if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state_q      <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid/dirty bookkeeping: fills install clean lines, store hits dirty them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[miss_idx_q] <= 1'b1;
      dirty_q[miss_idx_q] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[cpu_idx] <= 1'b1;
    end
  end

  // Tag and data arrays (no reset): line fill or single-word store merge.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_q[miss_idx_q] <= mem_data_i;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (store_hit) begin
      data_q[cpu_idx][{cpu_word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl. A behavioural memory
// responder acks after a programmable delay and checks each memory
// transaction against an expected queue; CPU accesses push the expected load
// data and stall length, which are popped once the stall drops.
module tb_dcache_ctrl;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_txn_t;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } cpu_exp_t;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_dly = 4;
  bit late_ack = 0;

  mem_txn_t    mem_exp[$];
  cpu_exp_t    cpu_exp[$];
  logic [31:0] mem_w [logic [31:0]];
  logic [31:0] cpu_w [logic [31:0]];
  logic [31:0] cv, cd;
  logic [21:0] ct [32];

  dcache_ctrl #(.LINES(32), .LINE_W(256)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    return mem_w.exists(wa) ? mem_w[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] cpu_word(input logic [31:0] wa);
    return cpu_w.exists(wa) ? cpu_w[wa] : init_word(wa);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [255:0] cpu_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = cpu_word(la + 32'(i * 4));
    return l;
  endfunction

  // Memory responder: acks on the ack_dly-th enabled cycle, checks the
  // request against the expected queue and supplies fill data.
  initial begin
    int       cnt;
    mem_txn_t t;
    cnt        = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (late_ack) begin
        mem_ack_i = 1'b1;
        late_ack  = 0;
      end else if (mem_enable_o && !rst_i) begin
        cnt++;
        if (cnt >= ack_dly) begin
          cnt = 0;
          if (mem_exp.size() == 0) begin
            check("mem_unexpected_req", 256'(mem_enable_o), 256'(0));
          end else begin
            t = mem_exp.pop_front();
            check("mem_write", 256'(mem_write_o), 256'(t.wr));
            check("mem_addr", 256'(mem_addr_o), 256'(t.addr));
            if (t.wr) begin
              check("wb_data", mem_data_o, t.data);
              for (int i = 0; i < 8; i++) mem_w[t.addr + 32'(i * 4)] = t.data[i*32 +: 32];
            end else begin
              mem_data_i = mem_line(t.addr);
            end
            mem_ack_i = 1'b1;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One CPU access: update the cache model, push expectations, hold the
  // request until the stall drops, then compare.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [4:0]  idx;
    logic [21:0] tg;
    logic [31:0] la, wa, old;
    int          exp_stall, stalls;
    bit          done;
    cpu_exp_t    e;
    idx = a[9:5];
    tg  = a[31:10];
    la  = {a[31:5], 5'b0};
    wa  = {a[31:2], 2'b0};
    exp_stall = 0;
    if (!(cv[idx] && ct[idx] == tg)) begin
      exp_stall = ack_dly + 3;
      if (cv[idx] && cd[idx]) begin
        old = {ct[idx], idx, 5'b0};
        mem_exp.push_back('{1'b1, old, cpu_line(old)});
        exp_stall += ack_dly + 1;
      end
      mem_exp.push_back('{1'b0, la, 256'(0)});
      cv[idx] = 1'b1;
      cd[idx] = 1'b0;
      ct[idx] = tg;
    end
    if (wr) begin
      cpu_w[wa] = d;
      cd[idx]   = 1'b1;
      e.data    = '0;
    end else begin
      e.data = rd ? cpu_word(wa) : '0;
    end
    e.stall = exp_stall;
    cpu_exp.push_back(e);

    cpu_addr_i     = a;
    cpu_data_i     = d;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o) stalls++;
      else done = 1;
    end
    if (!done) check("stall_timeout", 256'(cpu_stall_o), 256'(0));
    e = cpu_exp.pop_front();
    check("cpu_data", 256'(cpu_data_o), 256'(e.data));
    check("stall_len", 256'(stalls), 256'(e.stall));
    @(posedge clk_i);
    #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    bit seen;
    cv = '0;
    cd = '0;
    mem_w[32'h104] = 32'hDEAD_BEEF;
    cpu_w[32'h104] = 32'hDEAD_BEEF;
    rst_i          = 1'b1;
    cpu_addr_i     = 32'h100;
    cpu_data_i     = '0;
    cpu_MemRead_i  = 1'b1;
    cpu_MemWrite_i = 1'b0;

    // Reset: all outputs zero, stall suppressed even with a request present.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_stall", 256'(cpu_stall_o), 256'(0));
    check("rst_cpu_data", 256'(cpu_data_o), 256'(0));
    check("rst_mem_enable", 256'(mem_enable_o), 256'(0));
    check("rst_mem_write", 256'(mem_write_o), 256'(0));
    check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    check("rst_mem_data", mem_data_o, 256'(0));
    @(posedge clk_i);
    #1;
    cpu_MemRead_i = 1'b0;
    rst_i         = 1'b0;
    @(posedge clk_i);
    #1;

    // Clean miss fill (A=4), then hit on DEADBEEF word.
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0104, 32'h0);
    // Store hit, read back.
    access(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    // Conflict miss on dirty line: write-back then fill; then evict back.
    access(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    // Store miss to a clean line with A=1, merged word and neighbour.
    ack_dly = 1;
    access(1'b0, 1'b1, 32'h0000_0208, 32'hA5A5_5A5A);
    access(1'b1, 1'b0, 32'h0000_0208, 32'h0);
    access(1'b1, 1'b0, 32'h0000_020C, 32'h0);
    ack_dly = 4;
    // Read and write together on a hit: store wins, no load data.
    access(1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'h0000_0104, 32'h0);

    // Flush: request dropped mid-miss; the fill still completes.
    mem_exp.push_back('{1'b0, 32'h0000_0300, 256'(0)});
    cv[24] = 1'b1;
    cd[24] = 1'b0;
    ct[24] = '0;
    cpu_addr_i    = 32'h0000_0300;
    cpu_MemRead_i = 1'b1;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    cpu_MemRead_i = 1'b0;
    for (int c = 0; c < 100 && mem_exp.size() != 0; c++) @(negedge clk_i);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("flush_stall", 256'(cpu_stall_o), 256'(0));
    check("flush_idle_enable", 256'(mem_enable_o), 256'(0));
    @(posedge clk_i);
    #1;
    access(1'b1, 1'b0, 32'h0000_0300, 32'h0);

    // Reset during FILL, late ack ignored, lines invalidated.
    ack_dly       = 20;
    cpu_addr_i    = 32'h0000_0700;
    cpu_MemRead_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check("fill_enable", 256'(mem_enable_o), 256'(1));
    check("fill_addr", 256'(mem_addr_o), 256'(32'h0000_0700));
    @(posedge clk_i);
    #1;
    rst_i         = 1'b1;
    cpu_MemRead_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_stall", 256'(cpu_stall_o), 256'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mem_exp.delete();
    cv    = '0;
    cd    = '0;
    cpu_w = mem_w;
    @(negedge clk_i);
    check("rst_mid_enable", 256'(mem_enable_o), 256'(0));
    check("rst_mid_addr", 256'(mem_addr_o), 256'(0));
    check("rst_mid_stall_after", 256'(cpu_stall_o), 256'(0));
    @(posedge clk_i);
    #1;
    late_ack = 1;
    seen     = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (mem_enable_o || cpu_stall_o) seen = 1;
    end
    check("late_ack_ignored", 256'(seen), 256'(0));
    @(posedge clk_i);
    #1;
    ack_dly = 4;
    access(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0104, 32'h0);

    repeat (2) @(posedge clk_i);
    check("mem_pending", 256'(mem_exp.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
